// File: rtl/txfifo_route_n.sv
// Transmit FIFO/router: steers each input packet into one of NCH per-channel FIFOs.
// Define TXFIFO_ROUTE_STORE_FWD_EN for store-and-forward output release (default: cut-through).
module txfifo_route_n #(
  parameter int NCH   = 3,
  parameter int DW    = 32,
  parameter int UW    = 4,
  parameter int SW    = 4,
  parameter int DEPTH = 16,
  parameter int RAW   = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [DW-1:0]     s_tdata,
  input  logic [UW-1:0]     s_tuser,
  input  logic [SW-1:0]     s_tstrb,
  input  logic              s_tlast,
  output logic [NCH-1:0]    m_tvalid,
  input  logic [NCH-1:0]    m_tready,
  output logic [NCH*DW-1:0] m_tdata,
  output logic [NCH*UW-1:0] m_tuser,
  output logic [NCH*SW-1:0] m_tstrb,
  output logic [NCH-1:0]    m_tlast,
  input  logic              reg_wr,
  input  logic              reg_rd,
  input  logic [RAW-1:0]    reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata
);

  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int EW   = DW + UW + SW + 1;

  typedef enum logic {IDLE, PKT} state_t;

  state_t            state, state_nxt;
  logic [SELW-1:0]   dest_q, dest_c;
  logic              drop_q, drop_c;
  logic              full_sel, en_sel;
  logic              accept, drop_inc;
  logic [NCH-1:0]    ctrl;
  logic [15:0]       drop_cnt;
  logic [31:0]       rd_val;

  logic [EW-1:0]     mem [NCH][DEPTH];
  logic [EW-1:0]     head [NCH];
  logic [AW:0]       wp [NCH];
  logic [AW:0]       rp [NCH];
  logic [AW:0]       level [NCH];
  logic [NCH-1:0]    full, empty, push, pop, valid;

  logic              unused_ok;
  assign unused_ok = ^reg_wdata[31:NCH];

  // First beat routes on the live tuser; later beats reuse the latched decision.
  always_comb begin
    dest_c   = (state == IDLE) ? s_tuser[SELW-1:0] : dest_q;
    full_sel = 1'b0;
    en_sel   = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (dest_c == SELW'(i)) begin
        full_sel = full[i];
        en_sel   = ctrl[i];
      end
    end
    drop_c   = (state == IDLE) ? ((32'(dest_c) >= 32'(NCH)) || !en_sel) : drop_q;
    s_tready = rstn && (drop_c || !full_sel);
    accept   = s_tvalid && s_tready;
    drop_inc = accept && drop_c && s_tlast;
    push     = '0;
    for (int unsigned i = 0; i < NCH; i++)
      push[i] = accept && !drop_c && (dest_c == SELW'(i));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && !s_tlast) state_nxt = PKT;
      PKT:  if (accept && s_tlast)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      dest_q <= '0;
      drop_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && accept) begin
        dest_q <= dest_c;
        drop_q <= drop_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NCH; i++)
      if (push[i]) mem[i][wp[i][AW-1:0]] <= {s_tlast, s_tstrb, s_tuser, s_tdata};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        wp[i] <= '0;
        rp[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (push[i]) wp[i] <= wp[i] + 1'b1;
        if (pop[i])  rp[i] <= rp[i] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      level[i] = wp[i] - rp[i];
      full[i]  = level[i][AW];
      empty[i] = (level[i] == '0);
      head[i]  = mem[i][rp[i][AW-1:0]];
    end
  end

`ifdef TXFIFO_ROUTE_STORE_FWD_EN
  logic [AW:0] pkt_cnt [NCH];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NCH; i++) pkt_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if ((push[i] && s_tlast) && !(pop[i] && head[i][EW-1]))
          pkt_cnt[i] <= pkt_cnt[i] + 1'b1;
        else if (!(push[i] && s_tlast) && (pop[i] && head[i][EW-1]))
          pkt_cnt[i] <= pkt_cnt[i] - 1'b1;
      end
    end
  end

  // A full FIFO is released even without a complete packet so long packets cannot deadlock.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++)
      valid[i] = (pkt_cnt[i] != '0) || full[i];
  end
`else
  always_comb valid = ~empty;
`endif

  always_comb begin
    m_tvalid = valid;
    pop      = valid & m_tready;
    m_tdata  = '0;
    m_tuser  = '0;
    m_tstrb  = '0;
    m_tlast  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (valid[i]) begin
        m_tdata[i*DW +: DW] = head[i][DW-1:0];
        m_tuser[i*UW +: UW] = head[i][DW +: UW];
        m_tstrb[i*SW +: SW] = head[i][DW+UW +: SW];
        m_tlast[i]          = head[i][EW-1];
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (reg_addr == RAW'(0)) rd_val = 32'(ctrl);
    if (reg_addr == RAW'(4)) rd_val = 32'(drop_cnt);
    for (int unsigned i = 0; i < NCH; i++)
      if (reg_addr == RAW'(16 + 4*i)) rd_val = 32'(level[i]);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ctrl      <= '1;
      drop_cnt  <= '0;
      reg_rdata <= '0;
    end else begin
      if (reg_wr && reg_addr == RAW'(0)) ctrl <= reg_wdata[NCH-1:0];
      if (reg_wr && reg_addr == RAW'(4))
        drop_cnt <= '0;
      else if (drop_inc && drop_cnt != '1)
        drop_cnt <= drop_cnt + 1'b1;
      if (reg_rd) reg_rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_txfifo_route_n.sv
// Directed bench for txfifo_route_n: per-cycle vector table plus hand-written corner sequences.
module tb_txfifo_route_n;
  localparam int NCH = 3, DW = 32, UW = 4, SW = 4, DEPTH = 16, RAW = 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic              s_tvalid, s_tready, s_tlast;
  logic [DW-1:0]     s_tdata;
  logic [UW-1:0]     s_tuser;
  logic [SW-1:0]     s_tstrb;
  logic [NCH-1:0]    m_tvalid, m_tready, m_tlast;
  logic [NCH*DW-1:0] m_tdata;
  logic [NCH*UW-1:0] m_tuser;
  logic [NCH*SW-1:0] m_tstrb;
  logic              reg_wr, reg_rd;
  logic [RAW-1:0]    reg_addr;
  logic [31:0]       reg_wdata, reg_rdata;

  int checks = 0;
  int errors = 0;

  txfifo_route_n #(.NCH(NCH), .DW(DW), .UW(UW), .SW(SW), .DEPTH(DEPTH), .RAW(RAW)) dut (
    .clk(clk), .rstn(rstn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tuser(s_tuser),
    .s_tstrb(s_tstrb), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tuser(m_tuser),
    .m_tstrb(m_tstrb), .m_tlast(m_tlast),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [3:0]  user;
    logic [31:0] data;
    logic        last;
    logic        exp_rdy;
    logic [2:0]  exp_mv;
    logic [31:0] exp_d1;
    logic        exp_l1;
  } vec_t;

  typedef struct {
    int          ch;
    logic [31:0] d;
    logic        l;
  } obs_t;

  vec_t tbl [9];
  obs_t obs [$];

  always @(negedge clk) begin
    if (rstn) begin
      for (int i = 0; i < NCH; i++)
        if (m_tvalid[i] && m_tready[i])
          obs.push_back('{ch: i, d: m_tdata[i*DW +: DW], l: m_tlast[i]});
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    step();
    reg_wr = 1'b0;
  endtask

  task automatic reg_read(input logic [7:0] a, output logic [31:0] d);
    reg_rd = 1'b1; reg_addr = a;
    step();
    reg_rd = 1'b0;
    d = reg_rdata;
  endtask

  task automatic send_beat(input logic [3:0] u, input logic [31:0] d, input logic l, output int waited);
    s_tvalid = 1'b1; s_tuser = u; s_tdata = d; s_tlast = l; s_tstrb = 4'hF;
    waited = 0;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      waited++;
      if (waited > 300) begin
        chk("send_timeout", 32'(waited), 32'd0);
        break;
      end
      step();
    end
    step();
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic drain(input int n);
    int c = 0;
    while (obs.size() < n && c < 200) begin
      step();
      c++;
    end
    chk("drain_count", 32'(obs.size()), 32'(n));
  endtask

  logic [31:0] rd;
  int          w;

  initial begin
`ifdef TXFIFO_ROUTE_STORE_FWD_EN
    tbl[0] = '{1'b1, 4'd1, 32'hA0, 1'b0, 1'b1, 3'b000, 32'h0,  1'b0};
    tbl[1] = '{1'b1, 4'd1, 32'hA1, 1'b0, 1'b1, 3'b000, 32'h0,  1'b0};
    tbl[2] = '{1'b1, 4'd1, 32'hA2, 1'b0, 1'b1, 3'b000, 32'h0,  1'b0};
    tbl[3] = '{1'b1, 4'd1, 32'hA3, 1'b1, 1'b1, 3'b000, 32'h0,  1'b0};
    tbl[4] = '{1'b0, 4'd0, 32'h0,  1'b0, 1'b1, 3'b010, 32'hA0, 1'b0};
    tbl[5] = '{1'b0, 4'd0, 32'h0,  1'b0, 1'b1, 3'b010, 32'hA1, 1'b0};
    tbl[6] = '{1'b0, 4'd0, 32'h0,  1'b0, 1'b1, 3'b010, 32'hA2, 1'b0};
    tbl[7] = '{1'b0, 4'd0, 32'h0,  1'b0, 1'b1, 3'b010, 32'hA3, 1'b1};
    tbl[8] = '{1'b0, 4'd0, 32'h0,  1'b0, 1'b1, 3'b000, 32'h0,  1'b0};
`else
    tbl[0] = '{1'b1, 4'd1, 32'hA0, 1'b0, 1'b1, 3'b000, 32'h0,  1'b0};
    tbl[1] = '{1'b1, 4'd1, 32'hA1, 1'b0, 1'b1, 3'b010, 32'hA0, 1'b0};
    tbl[2] = '{1'b1, 4'd1, 32'hA2, 1'b0, 1'b1, 3'b010, 32'hA1, 1'b0};
    tbl[3] = '{1'b1, 4'd1, 32'hA3, 1'b1, 1'b1, 3'b010, 32'hA2, 1'b0};
    tbl[4] = '{1'b0, 4'd0, 32'h0,  1'b0, 1'b1, 3'b010, 32'hA3, 1'b1};
    tbl[5] = '{1'b0, 4'd0, 32'h0,  1'b0, 1'b1, 3'b000, 32'h0,  1'b0};
    tbl[6] = '{1'b0, 4'd0, 32'h0,  1'b0, 1'b1, 3'b000, 32'h0,  1'b0};
    tbl[7] = '{1'b0, 4'd0, 32'h0,  1'b0, 1'b1, 3'b000, 32'h0,  1'b0};
    tbl[8] = '{1'b0, 4'd0, 32'h0,  1'b0, 1'b1, 3'b000, 32'h0,  1'b0};
`endif

    rstn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tuser = '0; s_tstrb = '0; s_tlast = 1'b0;
    m_tready = 3'b111; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0;
    step(); step();
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tdata", m_tdata[31:0] | m_tdata[63:32] | m_tdata[95:64], 32'd0);
    chk("rst_reg_rdata", reg_rdata, 32'd0);
    rstn = 1'b1;
    step();
    reg_read(8'h00, rd); chk("rst_ctrl", rd, 32'h7);

    // 4-beat packet to channel 1, per-cycle expectations
    for (int i = 0; i < 9; i++) begin
      s_tvalid = tbl[i].vld; s_tuser = tbl[i].user; s_tdata = tbl[i].data;
      s_tlast = tbl[i].last; s_tstrb = 4'hF;
      @(negedge clk);
      chk($sformatf("tbl%0d_s_tready", i), 32'(s_tready), 32'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_m_tvalid", i), 32'(m_tvalid), 32'(tbl[i].exp_mv));
      chk($sformatf("tbl%0d_m_tdata1", i), m_tdata[DW +: DW], tbl[i].exp_d1);
      chk($sformatf("tbl%0d_m_tlast1", i), 32'(m_tlast[1]), 32'(tbl[i].exp_l1));
      step();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    reg_read(8'h14, rd); chk("level1_empty", rd, 32'd0);

    // Fill channel 0 with 17 beats while its output is stalled
    obs.delete();
    m_tready = 3'b110;
    for (int k = 0; k < 16; k++) begin
      send_beat(4'd0, 32'(k), 1'b0, w);
      chk("fill_no_wait", 32'(w), 32'd0);
    end
    s_tvalid = 1'b1; s_tuser = 4'd0; s_tdata = 32'd16; s_tlast = 1'b1;
    @(negedge clk);
    chk("full_blocks", 32'(s_tready), 32'd0);
    step();
    reg_read(8'h10, rd); chk("level0_full", rd, 32'd16);
    chk("full_still_blocks", 32'(s_tready), 32'd0);
    m_tready = 3'b111;
    send_beat(4'd0, 32'd16, 1'b1, w);
    chk("no_passthru_wait", 32'(w), 32'd1);
    drain(17);
    for (int k = 0; k < 17 && k < obs.size(); k++) begin
      chk($sformatf("fill_ch%0d", k), 32'(obs[k].ch), 32'd0);
      chk($sformatf("fill_data%0d", k), obs[k].d, 32'(k));
      chk($sformatf("fill_last%0d", k), 32'(obs[k].l), 32'(k == 16));
    end
    reg_read(8'h10, rd); chk("level0_drained", rd, 32'd0);

    // Disabled channel: packet is swallowed and counted
    reg_write(8'h00, 32'h5);
    obs.delete();
    for (int k = 0; k < 3; k++) begin
      send_beat(4'd1, 32'hB0 + 32'(k), k == 2, w);
      chk($sformatf("drop_rdy%0d", k), 32'(w), 32'd0);
    end
    step(); step();
    chk("drop_no_output", 32'(obs.size()), 32'd0);
    chk("drop_m_tvalid", 32'(m_tvalid), 32'd0);
    reg_read(8'h04, rd); chk("drop_cnt_1", rd, 32'd1);
    reg_write(8'h04, 32'h0);
    reg_read(8'h04, rd); chk("drop_cnt_clr", rd, 32'd0);
    reg_write(8'h00, 32'h7);

    // Out-of-range destination, then a normal packet to channel 2
    send_beat(4'd3, 32'hC0, 1'b0, w);
    send_beat(4'd3, 32'hC1, 1'b1, w);
    reg_read(8'h04, rd); chk("drop_oor", rd, 32'd1);
    obs.delete();
    send_beat(4'd2, 32'hD0, 1'b0, w);
    send_beat(4'd2, 32'hD1, 1'b1, w);
    drain(2);
    if (obs.size() >= 2) begin
      chk("oor_next_ch", 32'(obs[0].ch), 32'd2);
      chk("oor_next_d0", obs[0].d, 32'hD0);
      chk("oor_next_d1", obs[1].d, 32'hD1);
      chk("oor_next_last", 32'(obs[1].l), 32'd1);
    end

    // Unmapped address: reads 0, write ignored
    reg_write(8'h08, 32'hFFFF_FFFF);
    reg_read(8'h08, rd); chk("unmapped_rd", rd, 32'd0);
    reg_read(8'h00, rd); chk("ctrl_unchanged", rd, 32'h7);

    // Reset mid-packet with 5 entries queued
    reg_write(8'h00, 32'h3);
    m_tready = 3'b110;
    for (int k = 0; k < 5; k++) send_beat(4'd0, 32'hE0 + 32'(k), 1'b0, w);
    reg_read(8'h10, rd); chk("level0_5", rd, 32'd5);
    rstn = 1'b0;
    step();
    chk("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("midrst_s_tready", 32'(s_tready), 32'd0);
    rstn = 1'b1;
    reg_read(8'h10, rd); chk("midrst_level0", rd, 32'd0);
    reg_read(8'h00, rd); chk("midrst_ctrl", rd, 32'h7);
    m_tready = 3'b111;
    obs.delete();
    send_beat(4'd2, 32'hE9, 1'b1, w);
    drain(1);
    if (obs.size() >= 1) chk("midrst_idle_route", 32'(obs[0].ch), 32'd2);

`ifdef TXFIFO_ROUTE_STORE_FWD_EN
    // Store-and-forward: held until tlast stored, then back-to-back
    send_beat(4'd0, 32'hF0, 1'b0, w);
    chk("sf_hold0", 32'(m_tvalid[0]), 32'd0);
    send_beat(4'd0, 32'hF1, 1'b0, w);
    chk("sf_hold1", 32'(m_tvalid[0]), 32'd0);
    send_beat(4'd0, 32'hF2, 1'b1, w);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("sf_valid%0d", c), 32'(m_tvalid[0]), 32'd1);
      chk($sformatf("sf_data%0d", c), m_tdata[31:0], 32'hF0 + 32'(c));
      step();
    end
    @(negedge clk);
    chk("sf_done", 32'(m_tvalid[0]), 32'd0);
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
